tree_port_arbiter: RTL

- Clocked round-robin arbiter for one output channel of a tree router node.
- NUM_IN requesters compete for the port; for a leaf-level node these are the two child links and the parent link.
- Winning 11-bit packets (5-bit route field, 3-bit source, 3-bit destination) are registered into a one-entry output buffer and presented on a valid/ready channel.
- The block sequences grants, holds losers off with backpressure, and guarantees starvation-free service.

---
 rtl/tree_port_arbiter_if.sv | 26 ++
 rtl/tree_port_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/tree_port_arbiter_if.sv
// tree_port_arbiter_if: request/response channel bundle for one output port
// of a tree router node.
//   master : requester/downstream side (drives in_valid, in_data, out_ready)
//   slave  : arbiter side (drives in_ready, out_valid, out_data)
// Packet i occupies in_data[i*WIDTH +: WIDTH].
interface tree_port_arbiter_if #(
  parameter int WIDTH  = 11,
  parameter int NUM_IN = 3
);
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_ready;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic                    out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/tree_port_arbiter.sv
// tree_port_arbiter: round-robin arbiter for one output channel of a tree
// router node. NUM_IN requesters compete; the winner's packet is registered
// into a one-entry output buffer presented on a valid/ready channel.
// Throughput is one packet per cycle when downstream keeps out_ready high.
//
// Optional feature: define TREE_ARB_GRANT_CNT_EN to build per-input
// saturating accepted-packet counters on grant_cnt. Without the macro the
// counters are not built and grant_cnt is tied to zero.
module tree_port_arbiter #(
  parameter int WIDTH  = 11,
  parameter int NUM_IN = 3,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  tree_port_arbiter_if.slave      bus,
  output logic [NUM_IN*CNT_W-1:0] grant_cnt
);

  localparam int PTR_W = $clog2(NUM_IN);

  // Buffer state: EMPTY accepts unconditionally, FULL only when draining.
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]       state_q,    state_d;
  logic [PTR_W-1:0] rr_ptr_q,   rr_ptr_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  logic             win_found;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W:0]   scan_sum;
  logic [PTR_W-1:0] scan_idx;
  logic [WIDTH-1:0] win_data;
  logic [PTR_W-1:0] next_ptr;
  logic             can_accept;
  logic             in_xfer;
  logic             out_xfer;

  // Round-robin pick: first valid requester scanning from rr_ptr upward.
  // NOTE: every variable assigned in always_comb gets a default before any
  // conditional assignment, otherwise synthesis infers a latch to hold it.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      scan_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (scan_sum >= (PTR_W+1)'(NUM_IN)) begin
        scan_sum = scan_sum - (PTR_W+1)'(NUM_IN);
      end
      scan_idx = scan_sum[PTR_W-1:0];
      if (!win_found && bus.in_valid[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Select the winner's packet with constant slices (no variable part-select).
  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (win_idx == PTR_W'(i)) begin
        win_data = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Pointer advances to just past the winner, wrapping at NUM_IN-1.
  always_comb begin
    if (win_idx == PTR_W'(NUM_IN - 1)) begin
      next_ptr = '0;
    end else begin
      next_ptr = win_idx + PTR_W'(1);
    end
  end

  // Handshake qualification. An empty buffer accepts regardless of
  // out_ready; a full one only when it drains on the same edge.
  always_comb begin
    can_accept = (state_q == ST_EMPTY) || bus.out_ready;
    in_xfer    = win_found && can_accept;
    out_xfer   = (state_q == ST_FULL) && bus.out_ready;
  end

  // One-hot ready to the winner only; forced low while reset is held so no
  // requester sees a grant during reset.
  always_comb begin
    bus.in_ready = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      bus.in_ready[i] = rst_n && in_xfer && (win_idx == PTR_W'(i));
    end
  end

  // Buffer/FSM next state: a load wins over a drain, giving back-to-back flow.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    out_data_d = out_data_q;
    if (in_xfer) begin
      state_d    = ST_FULL;
      rr_ptr_d   = next_ptr;
      out_data_d = win_data;
    end else if (out_xfer) begin
      state_d = ST_EMPTY;
    end
  end

  // State registers; async reset drops any buffered packet immediately.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      rr_ptr_q   <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      out_data_q <= out_data_d;
    end
  end

  assign bus.out_valid = (state_q == ST_FULL);
  assign bus.out_data  = out_data_q;

`ifdef TREE_ARB_GRANT_CNT_EN
  logic [CNT_W-1:0] cnt_q [NUM_IN];
  logic [CNT_W-1:0] cnt_d [NUM_IN];

  // Count accepted packets per input, saturating at all-ones.
  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      cnt_d[i] = cnt_q[i];
      if (in_xfer && (win_idx == PTR_W'(i)) && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Counter registers, cleared only by reset.
  // NOTE: this small register array is reset element by element because its
  // contents are architecturally visible; large RAM-style storage would not be.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_IN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Flatten counters onto the output bus, input i in slice i.
  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      grant_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end
`else
  assign grant_cnt = '0;
`endif

endmodule
